// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - state encoding and pattern/address helpers for the RAM BIST engine
package ram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_WR1,
        S_RD1,
        S_DRAIN0,
        S_DRAIN1,
        S_DONE
    } state_e;

    // Wide enough for any supported data/address width; callers truncate.
    localparam int unsigned CALC_W = 64;

    function automatic logic [CALC_W-1:0] pattern_of(input logic [CALC_W-1:0] seed,
                                                     input logic [31:0]       idx,
                                                     input logic              inv);
        logic [CALC_W-1:0] p;
        p = seed + CALC_W'(idx);
        return inv ? ~p : p;
    endfunction

    function automatic logic [CALC_W-1:0] addr_of(input logic [31:0] idx,
                                                  input logic [31:0] step);
        return CALC_W'(idx) * CALC_W'(step);
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - RAM-side bus between the BIST engine and the memory under test
interface ram_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_do;

    modport master (output mem_addr, output mem_wr, output mem_din, input mem_do);
    modport slave  (input mem_addr, input mem_wr, input mem_din, output mem_do);
endinterface

// File: rtl/ram_bist_checker.sv
// rtl/ram_bist_checker.sv - read-latency alignment, compare, saturating error count, first-fail capture
module ram_bist_checker #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] exp_data_i,
    input  logic [ADDR_W-1:0] exp_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              fail_o,
    output logic [7:0]        err_count_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_expected_o,
    output logic [DATA_W-1:0] fail_actual_o
);
    logic              cmp_v;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic              mismatch;

    logic              fail_q;
    logic [7:0]        err_count_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_expected_q;
    logic [DATA_W-1:0] fail_actual_q;

    generate
        if (READ_LAT == 0) begin : g_lat0
            assign cmp_v    = valid_i;
            assign cmp_exp  = exp_data_i;
            assign cmp_addr = exp_addr_i;
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst || clear_i) begin
                    cmp_v    <= 1'b0;
                    cmp_exp  <= '0;
                    cmp_addr <= '0;
                end else begin
                    cmp_v    <= valid_i;
                    cmp_exp  <= exp_data_i;
                    cmp_addr <= exp_addr_i;
                end
            end
        end
    endgenerate

    assign mismatch = cmp_v && (rd_data_i != cmp_exp);

    // Results are registered so rd_data never reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            fail_q          <= 1'b0;
            err_count_q     <= '0;
            fail_addr_q     <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
        end else if (mismatch) begin
            fail_q <= 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (!fail_q) begin
                fail_addr_q     <= cmp_addr;
                fail_expected_q <= cmp_exp;
                fail_actual_q   <= rd_data_i;
            end
        end
    end

    assign fail_o          = fail_q;
    assign err_count_o     = err_count_q;
    assign fail_addr_o     = fail_addr_q;
    assign fail_expected_o = fail_expected_q;
    assign fail_actual_o   = fail_actual_q;

endmodule

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - four-pass write/read/write-inverse/read BIST sequencer driving the RAM bus
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter int                NUM_WORDS = 64,
    parameter int                ADDR_STEP = 4,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(32'hA5A5_0000),
    parameter int                READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_expected,
    output logic [DATA_W-1:0] fail_actual,
    ram_bist_if.master        mem
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic              last, to_wr1, to_done, inv;
    logic              chk_valid;
    logic [DATA_W-1:0] chk_exp;

    function automatic logic [ADDR_W-1:0] a_of(input logic [IDX_W-1:0] i);
        return ADDR_W'(addr_of(32'(i), 32'(ADDR_STEP)));
    endfunction

    function automatic logic [DATA_W-1:0] p_of(input logic [IDX_W-1:0] i, input logic inv_i);
        return DATA_W'(pattern_of(CALC_W'(SEED), 32'(i), inv_i));
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        addr_d    = '0;
        wr_d      = 1'b0;
        din_d     = '0;
        to_wr1    = 1'b0;
        to_done   = 1'b0;
        last      = (idx_q == LAST);
        inv       = (state_q == S_WR1) || (state_q == S_RD1);
        chk_valid = 1'b0;
        chk_exp   = p_of(idx_q, inv);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    addr_d  = a_of('0);
                    wr_d    = 1'b1;
                    din_d   = p_of('0, 1'b0);
                end
            end
            S_WR0, S_WR1: begin
                if (last) begin
                    state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
                    idx_d   = '0;
                    addr_d  = a_of('0);
                end else begin
                    idx_d  = idx_q + 1'b1;
                    addr_d = a_of(idx_q + 1'b1);
                    wr_d   = 1'b1;
                    din_d  = p_of(idx_q + 1'b1, inv);
                end
            end
            S_RD0, S_RD1: begin
                chk_valid = 1'b1;
                if (last) begin
                    idx_d = '0;
                    if (READ_LAT > 0) begin
                        state_d = (state_q == S_RD0) ? S_DRAIN0 : S_DRAIN1;
                    end else if (state_q == S_RD0) begin
                        to_wr1 = 1'b1;
                    end else begin
                        to_done = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + 1'b1;
                    addr_d = a_of(idx_q + 1'b1);
                end
            end
            S_DRAIN0: to_wr1  = 1'b1;
            S_DRAIN1: to_done = 1'b1;
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (to_wr1) begin
            state_d = S_WR1;
            idx_d   = '0;
            addr_d  = a_of('0);
            wr_d    = 1'b1;
            din_d   = p_of('0, 1'b1);
        end
        if (to_done) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
        end
    end

    ram_bist_checker #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .clear_i        ((state_q == S_IDLE) && start),
        .valid_i        (chk_valid),
        .exp_data_i     (chk_exp),
        .exp_addr_i     (addr_q),
        .rd_data_i      (mem.mem_do),
        .fail_o         (fail),
        .err_count_o    (err_count),
        .fail_addr_o    (fail_addr),
        .fail_expected_o(fail_expected),
        .fail_actual_o  (fail_actual)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_wr   = wr_q;
    assign mem.mem_din  = din_q;

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - directed bench for ram_bist with synchronous and combinational RAM models
module tb_ram_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start0 = 1'b0;
    int   mode = 0;

    logic        busy1, done1, fail1, busy0, done0, fail0;
    logic [7:0]  err1, err0;
    logic [7:0]  faddr1, faddr0;
    logic [31:0] fexp1, fact1, fexp0, fact0;

    ram_bist_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();
    ram_bist_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

    ram_bist #(.NUM_WORDS(4), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .fail(fail1),
        .err_count(err1), .fail_addr(faddr1), .fail_expected(fexp1), .fail_actual(fact1),
        .mem(bus1)
    );

    ram_bist #(.NUM_WORDS(4), .READ_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .fail(fail0),
        .err_count(err0), .fail_addr(faddr0), .fail_expected(fexp0), .fail_actual(fact0),
        .mem(bus0)
    );

    always #5 clk = ~clk;

    // mode 0: good RAM, 1: bit 0 stuck-at-0 at byte address 8, 2: writes ignored / reads 0
    logic [31:0] ram1 [0:63];
    logic [31:0] do1_q;
    always @(posedge clk) begin
        if (bus1.mem_wr && mode != 2)
            ram1[bus1.mem_addr[7:2]] <= (mode == 1 && bus1.mem_addr == 8'd8) ?
                                        (bus1.mem_din & ~32'd1) : bus1.mem_din;
        do1_q <= (mode == 2) ? 32'd0 : ram1[bus1.mem_addr[7:2]];
    end
    assign bus1.mem_do = do1_q;

    logic [31:0] ram0 [0:63];
    always @(posedge clk) begin
        if (bus0.mem_wr) ram0[bus0.mem_addr[7:2]] <= bus0.mem_din;
    end
    assign bus0.mem_do = ram0[bus0.mem_addr[7:2]];

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    logic [39:0] exp_wr [8] = '{
        {8'd0,  32'hA5A5_0000}, {8'd4,  32'hA5A5_0001},
        {8'd8,  32'hA5A5_0002}, {8'd12, 32'hA5A5_0003},
        {8'd0,  32'h5A5A_FFFF}, {8'd4,  32'h5A5A_FFFE},
        {8'd8,  32'h5A5A_FFFD}, {8'd12, 32'h5A5A_FFFC}
    };

    int nbusy, ndone;
    logic [39:0] wq [$];

    task automatic run(input bit sel);
        nbusy = 0;
        ndone = 0;
        wq.delete();
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        for (int c = 0; c < 200 && ndone == 0; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (sel ? busy0 : busy1) nbusy++;
            if (sel ? bus0.mem_wr : bus1.mem_wr)
                wq.push_back(sel ? {bus0.mem_addr, bus0.mem_din} : {bus1.mem_addr, bus1.mem_din});
            if (sel ? done0 : done1) ndone++;
        end
        chk("run_done_seen", 64'(ndone), 64'd1);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < wq.size()) chk($sformatf("%s_wr%0d", tag, k), 64'(wq[k]), 64'(exp_wr[k]));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_fail", 64'(fail1), 64'd0);
        chk("rst_err", 64'(err1), 64'd0);
        chk("rst_faddr", 64'(faddr1), 64'd0);
        chk("rst_fexp", 64'(fexp1), 64'd0);
        chk("rst_fact", 64'(fact1), 64'd0);
        chk("rst_maddr", 64'(bus1.mem_addr), 64'd0);
        chk("rst_mwr", 64'(bus1.mem_wr), 64'd0);
        chk("rst_mdin", 64'(bus1.mem_din), 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);

        // clean run
        mode = 0;
        run(1'b0);
        chk("t1_busy", 64'(nbusy), 64'd18);
        chk_writes("t1");
        chk("t1_fail", 64'(fail1), 64'd0);
        chk("t1_err", 64'(err1), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done1), 64'd0);

        // stuck-at-0 on bit 0 at address 8
        mode = 1;
        run(1'b0);
        chk("t2_fail", 64'(fail1), 64'd1);
        chk("t2_err", 64'(err1), 64'd1);
        chk("t2_faddr", 64'(faddr1), 64'd8);
        chk("t2_fexp", 64'(fexp1), 64'h5A5A_FFFD);
        chk("t2_fact", 64'(fact1), 64'h5A5A_FFFC);
        repeat (3) @(negedge clk);
        chk("t2_hold_faddr", 64'(faddr1), 64'd8);
        chk("t2_hold_err", 64'(err1), 64'd1);

        // writes ignored, every read returns 0
        mode = 2;
        run(1'b0);
        chk("t3_fail", 64'(fail1), 64'd1);
        chk("t3_err", 64'(err1), 64'd8);
        chk("t3_faddr", 64'(faddr1), 64'd0);
        chk("t3_fexp", 64'(fexp1), 64'hA5A5_0000);
        chk("t3_fact", 64'(fact1), 64'd0);

        // start held high for 40 cycles: faulty first run, clean second run
        @(negedge clk);
        mode = 2;
        nbusy = 0;
        ndone = 0;
        start1 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy1) nbusy++;
            if (done1) ndone++;
            if (c == 18) begin
                chk("t4_done_a", 64'(done1), 64'd1);
                chk("t4_err_a", 64'(err1), 64'd8);
            end
            if (c == 19) begin
                chk("t4_idle_busy", 64'(busy1), 64'd0);
                mode = 0;
            end
            if (c == 20) begin
                chk("t4_restart_busy", 64'(busy1), 64'd1);
                chk("t4_restart_err", 64'(err1), 64'd0);
                chk("t4_restart_fail", 64'(fail1), 64'd0);
            end
            if (c == 38) begin
                chk("t4_done_b", 64'(done1), 64'd1);
                chk("t4_err_b", 64'(err1), 64'd0);
            end
        end
        start1 = 1'b0;
        chk("t4_busy_total", 64'(nbusy), 64'd36);
        chk("t4_done_count", 64'(ndone), 64'd2);
        @(negedge clk);
        chk("t4_no_third", 64'(busy1), 64'd0);

        // reset on the third WR0 cycle
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_wr3_addr", 64'(bus1.mem_addr), 64'd8);
        chk("t5_wr3_wr", 64'(bus1.mem_wr), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 64'(busy1), 64'd0);
        chk("t5_mwr", 64'(bus1.mem_wr), 64'd0);
        chk("t5_maddr", 64'(bus1.mem_addr), 64'd0);
        chk("t5_mdin", 64'(bus1.mem_din), 64'd0);
        chk("t5_status", 64'({fail1, err1, faddr1, fexp1 | fact1}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run(1'b0);
        chk("t5_rerun_busy", 64'(nbusy), 64'd18);
        chk("t5_rerun_fail", 64'(fail1), 64'd0);
        chk("t5_rerun_err", 64'(err1), 64'd0);

        // combinational-read RAM with READ_LAT=0
        run(1'b1);
        chk("t6_busy", 64'(nbusy), 64'd16);
        chk_writes("t6");
        chk("t6_fail", 64'(fail0), 64'd0);
        chk("t6_err", 64'(err0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test engine that sits directly upstream of the 256-byte, 32-bit RAM and drives its address, WR and Din inputs.
- It consumes the RAM's Do output and runs a four-pass pattern test: write pattern, read/compare, write inverse, read/compare.
- It reports pass/fail, first-failure details and an error count.
- In the lab top level it replaces the hand-sequenced stimulus as the RAM's driver during test.

Parameters:
- ADDR_W, 8, RAM address width (byte address).
- DATA_W, 32, RAM data width.
- NUM_WORDS, 64, number of words tested; must satisfy 1 <= NUM_WORDS <= 2^ADDR_W / ADDR_STEP.
- ADDR_STEP, 4, byte increment between words (word-aligned addresses 0, 4, 8, ...).
- SEED, 32'hA5A5_0000, pattern base value.
- READ_LAT, 1, RAM read latency in cycles from address to valid Do; legal values 0 or 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin test; sampled only in IDLE.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse when the test completes.
- fail  out  1  at least one mismatch seen in the last or current run.
- err_count  out  8  mismatch count; saturates at 255.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_expected  out  DATA_W  expected data at the first mismatch.
- fail_actual  out  DATA_W  data read at the first mismatch.
- mem_addr  out  ADDR_W  to RAM address.
- mem_wr  out  1  to RAM WR.
- mem_din  out  DATA_W  to RAM Din.
- mem_do  in  DATA_W  from RAM Do.

Behaviour:
- Reset, and all outputs while in IDLE after reset: busy=0, done=0, fail=0, err_count=0, fail_addr=0, fail_expected=0, fail_actual=0, mem_addr=0, mem_wr=0, mem_din=0.
- All outputs are registered.
- Pattern for word i: P(i) = SEED + i, truncated to DATA_W. Address for word i: A(i) = i*ADDR_STEP, truncated to ADDR_W.
- States: IDLE, WR0, RD0, WR1, RD1, DRAIN0, DRAIN1, DONE.
- IDLE -> WR0 on an edge with start=1 and rst=0. At that edge:
  - busy<=1.
  - fail, err_count and the fail_* registers are cleared.
  - mem_addr<=A(0), mem_wr<=1, mem_din<=P(0).
- WR0: drives A(i) and P(i) with mem_wr=1 for i = 0..NUM_WORDS-1, one word per cycle. After the last word, go to RD0.
- RD0: mem_wr=0, mem_din=0, drives A(i) for i = 0..NUM_WORDS-1, one per cycle.
  - Expected value and address travel through a READ_LAT-deep pipeline.
  - mem_do is compared against P(i) READ_LAT cycles after A(i) is presented. With READ_LAT=0 the compare happens in the same cycle.
- DRAIN0 lasts READ_LAT cycles (zero cycles when READ_LAT=0) so the final compare completes. Then go to WR1.
- WR1, RD1 and DRAIN1 mirror WR0, RD0 and DRAIN0 with data ~P(i).
- DONE lasts one cycle: done=1, busy=0. Next state is IDLE.
- Total cycles with busy=1: 4*NUM_WORDS + 2*READ_LAT.
- On a mismatch:
  - err_count increments, saturating at 255.
  - fail<=1.
  - fail_addr, fail_expected and fail_actual are captured only if fail was 0 before this compare (first failure wins).
- fail, err_count and fail_* hold their values in IDLE until the next accepted start.
- start while busy, or during DONE, is ignored. start held high continuously begins a new run on the edge after DONE, i.e. the first IDLE cycle.
- rst=1 at any edge, including mid-write or mid-drain, returns to IDLE with the reset values on that edge. mem_wr is therefore 0 from the next cycle, and partial RAM contents are not restored.
- No combinational path from mem_do to any output.

Decomposition:
- Package ram_bist_pkg holds:
  - the state enum;
  - a function that computes pattern P(i) and its inverse from SEED, i and the pass;
  - a function that computes address A(i).
- Sub-module ram_bist_checker holds the READ_LAT expected-data/address pipeline, the comparator, the saturating err_count and the first-fail capture registers. The parent FSM feeds it a valid strobe with the expected data and address.

Test Plan:
- Clean RAM, NUM_WORDS=4, READ_LAT=1, pulse start -> writes to 0/4/8/12 with 0xA5A50000..0xA5A50003, then reads, then writes 0x5A5AFFFF..0x5A5AFFFC and reads; busy high 18 cycles; done pulse; fail=0; err_count=0.
- Same, with RAM bit 0 stuck-at-0 at address 8 -> pass 1 clean; pass 2 mismatch; fail=1, err_count=1, fail_addr=8, fail_expected=0x5A5AFFFD, fail_actual=0x5A5AFFFC.
- RAM with WR ignored (all reads 0), NUM_WORDS=4 -> err_count=8; fail_addr=0; fail_expected=0xA5A50000; fail_actual=0.
- start held high for 40 cycles, NUM_WORDS=4 -> a second run begins on the first IDLE cycle after done; no start accepted while busy; per-run counters cleared at each start.
- rst asserted on the 3rd WR0 cycle -> next edge: busy=0, mem_wr=0, all status outputs 0; a subsequent start completes a clean run.
- READ_LAT=0 build with a combinational-read RAM, NUM_WORDS=4 -> busy 16 cycles; fail=0.
